// File: rtl/mapa_grid.sv
// Tile-map memory for the snake playfield: 2-bit cell per tile, a 2-stage render
// read port, a game-logic read/write port pair and a clear sequencer.
module mapa_grid #(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int COORD_BITS  = 10,
  parameter int BORDER      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  beating_high_score,
  input  logic                  game_over,
  input  logic                  vga_read,
  input  logic [COORD_BITS-1:0] renderer_rx,
  input  logic [COORD_BITS-1:0] renderer_ry,
  output logic [1:0]            mapa_R,
  output logic [1:0]            mapa_G,
  output logic [1:0]            mapa_B,
  output logic                  render_valid,
  input  logic                  update_renable,
  input  logic [COORD_BITS-1:0] update_rx,
  input  logic [COORD_BITS-1:0] update_ry,
  output logic [1:0]            update_rdata,
  output logic                  update_rvalid,
  input  logic                  update_wenable,
  input  logic [COORD_BITS-1:0] update_wx,
  input  logic [COORD_BITS-1:0] update_wy,
  input  logic [1:0]            update_wdata
);
  localparam int CELLS = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int AW    = $clog2(CELLS);
  localparam logic [AW-1:0]         LAST = AW'(CELLS - 1);
  localparam logic [COORD_BITS-1:0] XMAX = COORD_BITS'(MAPA_WIDTH - 1);
  localparam logic [COORD_BITS-1:0] YMAX = COORD_BITS'(MAPA_HEIGHT - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  function automatic logic in_range(input logic [COORD_BITS-1:0] x, input logic [COORD_BITS-1:0] y);
    return (x <= XMAX) && (y <= YMAX);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [COORD_BITS-1:0] x, input logic [COORD_BITS-1:0] y);
    return AW'(y) * AW'(MAPA_WIDTH) + AW'(x);
  endfunction

  logic [1:0] mem_q [CELLS];

  state_e                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [COORD_BITS-1:0]   sx_q, sx_d, sy_q, sy_d;

  // Sweep x/y are tracked alongside the linear index to avoid a divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      IDLE: if (clear_req) begin
        state_d = CLEAR;
        idx_d   = '0;
        sx_d    = '0;
        sy_d    = '0;
      end
      CLEAR: if (idx_q == LAST) begin
        state_d = IDLE;
        idx_d   = '0;
        sx_d    = '0;
        sy_d    = '0;
      end else begin
        idx_d = idx_q + 1'b1;
        if (sx_q == XMAX) begin
          sx_d = '0;
          sy_d = sy_q + 1'b1;
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = reset || (state_q == CLEAR);

  logic          we;
  logic [AW-1:0] waddr;
  logic [1:0]    wdata;
  logic          edge_tile;

  assign edge_tile = (sx_q == '0) || (sx_q == XMAX) || (sy_q == '0) || (sy_q == YMAX);

  // Sweep and logic writes are mutually exclusive, so one write port suffices.
  always_comb begin
    we    = 1'b0;
    waddr = idx_q;
    wdata = (BORDER != 0 && edge_tile) ? 2'b11 : 2'b00;
    if (state_q == CLEAR) begin
      we = !reset;
    end else if (!reset && update_wenable && in_range(update_wx, update_wy)) begin
      we    = 1'b1;
      waddr = addr_of(update_wx, update_wy);
      wdata = update_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  logic rd_ok;
  assign rd_ok = update_renable && !busy;

  // Off-map logic reads return obstacle so the game sees a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      update_rvalid <= 1'b0;
      update_rdata  <= 2'b00;
    end else begin
      update_rvalid <= rd_ok;
      if (rd_ok)
        update_rdata <= in_range(update_rx, update_ry) ? mem_q[addr_of(update_rx, update_ry)] : 2'b11;
    end
  end

  logic [2:1] vld_pipe_q;
  logic [1:0] code1_q;
  logic [5:0] rgb_d, rgb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      code1_q    <= 2'b00;
      rgb_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], vga_read};
      code1_q    <= in_range(renderer_rx, renderer_ry) ? mem_q[addr_of(renderer_rx, renderer_ry)] : 2'b00;
      rgb_q      <= vld_pipe_q[1] ? rgb_d : 6'b0;
    end
  end

  always_comb begin
    rgb_d = 6'b0;
    if (game_over) begin
      rgb_d = 6'b11_00_00;
    end else begin
      case (code1_q)
        2'b10:   rgb_d = 6'b11_00_00;
        2'b01:   rgb_d = {beating_high_score ? 2'b11 : 2'b00, 2'b11, 2'b00};
        2'b11:   rgb_d = 6'b00_00_11;
        default: rgb_d = 6'b0;
      endcase
    end
  end

  assign render_valid = vld_pipe_q[2];
  assign {mapa_R, mapa_G, mapa_B} = rgb_q;

endmodule

// File: tb/tb_mapa_grid.sv
// Directed bench for mapa_grid: vector table for reads/render plus sweep sequences.
module tb_mapa_grid;
  logic       clk = 1'b0;
  logic       reset, clear_req, busy, beating_high_score, game_over, vga_read;
  logic [9:0] renderer_rx, renderer_ry, update_rx, update_ry, update_wx, update_wy;
  logic [1:0] mapa_R, mapa_G, mapa_B, update_rdata, update_wdata;
  logic       render_valid, update_renable, update_rvalid, update_wenable;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mapa_grid dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy),
    .beating_high_score(beating_high_score), .game_over(game_over),
    .vga_read(vga_read), .renderer_rx(renderer_rx), .renderer_ry(renderer_ry),
    .mapa_R(mapa_R), .mapa_G(mapa_G), .mapa_B(mapa_B), .render_valid(render_valid),
    .update_renable(update_renable), .update_rx(update_rx), .update_ry(update_ry),
    .update_rdata(update_rdata), .update_rvalid(update_rvalid),
    .update_wenable(update_wenable), .update_wx(update_wx), .update_wy(update_wy),
    .update_wdata(update_wdata)
  );

  typedef struct {
    bit         render;
    int         x;
    int         y;
    bit         bhs;
    bit         go;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of logic-port traffic; returns read outputs one cycle later.
  task automatic lop(input bit we, input int wx, input int wy, input logic [1:0] wd,
                     input bit re, input int rx, input int ry,
                     output logic v, output logic [1:0] d);
    @(negedge clk);
    update_wenable = we; update_wx = 10'(wx); update_wy = 10'(wy); update_wdata = wd;
    update_renable = re; update_rx = 10'(rx); update_ry = 10'(ry);
    @(negedge clk);
    update_wenable = 1'b0; update_renable = 1'b0;
    v = update_rvalid; d = update_rdata;
  endtask

  task automatic lread(input string name, input int x, input int y, input logic [1:0] exp);
    logic v;
    logic [1:0] d;
    lop(1'b0, 0, 0, 2'b00, 1'b1, x, y, v, d);
    chk(name, {5'b0, v, d}, {5'b0, 1'b1, exp});
  endtask

  task automatic lwrite(input int x, input int y, input logic [1:0] wd);
    logic v;
    logic [1:0] d;
    lop(1'b1, x, y, wd, 1'b0, 0, 0, v, d);
  endtask

  task automatic render(input string name, input int x, input int y, input bit bhs,
                        input bit go, input logic [5:0] exp);
    @(negedge clk);
    vga_read = 1'b1; renderer_rx = 10'(x); renderer_ry = 10'(y);
    beating_high_score = bhs; game_over = go;
    @(negedge clk);
    vga_read = 1'b0;
    chk({name, "_early"}, {7'b0, render_valid}, 8'h00);
    @(negedge clk);
    chk(name, {1'b0, render_valid, mapa_R, mapa_G, mapa_B}, {2'b01, exp});
  endtask

  // Counts cycles busy stays high, optionally injecting traffic at given counts.
  task automatic sweep(input int act_clr, input int act_wr, input int act_rd, output int n);
    n = 0;
    #1;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
      if (act_rd > 0 && n == act_rd + 1) chk("rd_while_busy", {7'b0, update_rvalid}, 8'h00);
      clear_req = 1'b0; update_wenable = 1'b0; update_renable = 1'b0;
      if (n == act_clr) clear_req = 1'b1;
      if (n == act_wr) begin
        update_wenable = 1'b1; update_wx = 10'd5; update_wy = 10'd3; update_wdata = 2'b10;
      end
      if (n == act_rd) begin
        update_renable = 1'b1; update_rx = 10'd0; update_ry = 10'd0;
      end
      #1;
    end
    clear_req = 1'b0; update_wenable = 1'b0; update_renable = 1'b0;
  endtask

  initial begin
    int n;
    logic v;
    logic [1:0] d;

    vecs[0]  = '{0, 0, 0, 0, 0, 6'b000011};
    vecs[1]  = '{0, 39, 5, 0, 0, 6'b000011};
    vecs[2]  = '{0, 7, 29, 0, 0, 6'b000011};
    vecs[3]  = '{0, 1, 1, 0, 0, 6'b000000};
    vecs[4]  = '{0, 40, 0, 0, 0, 6'b000011};
    vecs[5]  = '{0, 0, 30, 0, 0, 6'b000011};
    vecs[6]  = '{1, 2, 2, 0, 0, 6'b00_11_00};
    vecs[7]  = '{1, 2, 2, 1, 0, 6'b11_11_00};
    vecs[8]  = '{1, 2, 2, 1, 1, 6'b11_00_00};
    vecs[9]  = '{1, 50, 1, 0, 0, 6'b00_00_00};
    vecs[10] = '{1, 0, 0, 0, 0, 6'b00_00_11};
    vecs[11] = '{1, 5, 3, 0, 0, 6'b11_00_00};

    reset = 1'b1; clear_req = 1'b0; beating_high_score = 1'b0; game_over = 1'b0;
    vga_read = 1'b0; renderer_rx = '0; renderer_ry = '0;
    update_renable = 1'b0; update_rx = '0; update_ry = '0;
    update_wenable = 1'b0; update_wx = '0; update_wy = '0; update_wdata = '0;

    @(negedge clk);
    chk("rst_busy", {7'b0, busy}, 8'h01);
    chk("rst_rvalid", {7'b0, render_valid}, 8'h00);
    chk("rst_rgb", {2'b0, mapa_R, mapa_G, mapa_B}, 8'h00);
    chk("rst_urvalid", {7'b0, update_rvalid}, 8'h00);
    chk("rst_urdata", {6'b0, update_rdata}, 8'h00);
    reset = 1'b0;
    sweep(0, 0, 0, n);
    chk("init_sweep_len", 8'(n / 8), 8'(1200 / 8));
    chk("init_sweep_len_lo", 8'(n % 8), 8'(1200 % 8));

    for (int i = 0; i < 6; i++)
      lread($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].exp[1:0]);

    lwrite(5, 3, 2'b10);
    lread("rd_5_3", 5, 3, 2'b10);
    lop(1'b1, 6, 3, 2'b01, 1'b1, 6, 3, v, d);
    chk("rw_same_cycle", {6'b0, v, d} , {6'b0, 1'b1, 2'b00});
    lread("rd_6_3_after", 6, 3, 2'b01);
    @(negedge clk);
    chk("rdata_hold", {5'b0, update_rvalid, update_rdata}, {5'b0, 1'b0, 2'b01});
    lwrite(45, 2, 2'b10);
    lread("oor_wr_5_2", 5, 2, 2'b00);
    lread("oor_wr_5_3", 5, 3, 2'b10);

    lwrite(2, 2, 2'b01);
    for (int i = 6; i < 12; i++)
      render($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bhs, vecs[i].go, vecs[i].exp);
    beating_high_score = 1'b0; game_over = 1'b0;

    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    sweep(300, 500, 700, n);
    chk("clr_sweep_len_hi", 8'(n / 8), 8'(1200 / 8));
    chk("clr_sweep_len_lo", 8'(n % 8), 8'(1200 % 8));
    lread("clr_5_3", 5, 3, 2'b00);
    lread("clr_6_3", 6, 3, 2'b00);
    lread("clr_0_0", 0, 0, 2'b11);

    lwrite(20, 20, 2'b10);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (600) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {7'b0, busy}, 8'h01);
    reset = 1'b0;
    sweep(0, 0, 0, n);
    chk("rst_sweep_len_hi", 8'(n / 8), 8'(1200 / 8));
    chk("rst_sweep_len_lo", 8'(n % 8), 8'(1200 % 8));
    lread("rst_20_20", 20, 20, 2'b00);
    lread("rst_39_29", 39, 29, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mapa_grid.md
Name: mapa_grid

Overview:
Parametrised tile-map memory for the snake playfield, holding one 2-bit cell code per tile (00 empty, 01 snake, 10 fruit, 11 obstacle). It has three ports: a pipelined render read port feeding the VGA colour path, a game-logic read port and a game-logic write port. A hardware clear sequencer wipes the map after reset or on request and can optionally draw an obstacle border. Out-of-range coordinates are handled safely on every port.

Parameters:
MAPA_WIDTH, 40, tiles per row
MAPA_HEIGHT, 30, tiles per column
COORD_BITS, 10, width of every x/y coordinate port
BORDER, 1, 1 = clear sweep writes 11 on edge tiles; 0 = all tiles 00

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clear_req  in  1  one-cycle pulse requesting a map clear
busy  out  1  high while reset is asserted or a clear sweep is running
beating_high_score  in  1  snake tiles tinted yellow
game_over  in  1  whole valid area shown red
vga_read  in  1  render read request
renderer_rx  in  COORD_BITS  render tile x
renderer_ry  in  COORD_BITS  render tile y
mapa_R  out  2  red
mapa_G  out  2  green
mapa_B  out  2  blue
render_valid  out  1  RGB corresponds to a request issued 2 cycles earlier
update_renable  in  1  logic read request
update_rx  in  COORD_BITS  logic read x
update_ry  in  COORD_BITS  logic read y
update_rdata  out  2  logic read data
update_rvalid  out  1  update_rdata valid this cycle
update_wenable  in  1  logic write request
update_wx  in  COORD_BITS  write x
update_wy  in  COORD_BITS  write y
update_wdata  in  2  write data

Behaviour:
- Storage: MAPA_WIDTH*MAPA_HEIGHT cells, row-major, address = y*MAPA_WIDTH + x. x indexes columns and y indexes rows on all ports.
- Reset:
  - While reset is high: state CLEAR, sweep index 0, busy=1, render_valid=0, RGB=0, update_rvalid=0, update_rdata=00.
  - Reset asserted mid-sweep restarts the sweep from index 0.
- FSM IDLE/CLEAR:
  - CLEAR writes one cell per cycle in raster order, starting the first cycle after reset deasserts.
  - Each cell gets 11 if BORDER=1 and x==0, x==W-1, y==0 or y==H-1; otherwise it gets 00.
  - After index W*H-1 is written, the FSM goes to IDLE and busy=0 on the next cycle. Sweep length is exactly W*H cycles.
  - clear_req in IDLE: next cycle enters CLEAR at index 0 with busy=1.
  - clear_req during CLEAR is ignored; the sweep does not restart.
- Logic ports while busy:
  - update_wenable is dropped.
  - update_renable is not accepted, so update_rvalid stays 0.
  - The render port keeps working and shows partially cleared content.
- Logic read:
  - A request accepted in cycle N gives update_rvalid=1 and update_rdata in cycle N+1.
  - update_rdata holds its value until the next accepted read.
  - An out-of-range read (x>=W or y>=H) returns 11, so a head off the map reads as a collision.
- Logic write:
  - Takes effect at the clock edge.
  - An out-of-range write is dropped and no cell changes.
- Read/write collision: a read of a cell written in the same cycle returns the old value (read-first). This applies to both read ports.
- Render pipeline, latency 2:
  - Stage 1: cell read. An out-of-range coordinate yields code 00 with no array access.
  - Stage 2: colour register. game_over and beating_high_score are sampled at stage 2.
  - render_valid is vga_read delayed 2 cycles. RGB=0 whenever render_valid=0.
- Colour map, applied when valid:
  - game_over: R=11, G=00, B=00, overriding all codes.
  - Code 10: R=11, G=00, B=00.
  - Code 01: G=11, B=00, R=11 if beating_high_score else R=00.
  - Code 11: R=00, G=00, B=11.
  - Code 00: all 0.
- Simultaneous events: render read, logic read and write may all occur in the same cycle and are independent.

Test Plan:
- Reset 1 cycle then release, defaults W=40, H=30, BORDER=1 -> busy high for exactly 1200 cycles after release. Afterwards, logic reads give 11 at (0,0), (39,5) and (7,29), and 00 at (1,1).
- Write (5,3)=10; next cycle logic read (5,3) -> update_rvalid=1, rdata=10. Same-cycle write (6,3)=01 plus read (6,3) -> read returns 00, and a later read returns 01.
- Logic read (40,0) and (0,30) -> rdata=11. Write (45,2)=10 -> no cell changes, including (5,2).
- With (2,2)=01, vga_read at (2,2): beating_high_score=0 -> RGB=00/11/00 two cycles later with render_valid=1. beating_high_score=1 -> 11/11/00. game_over=1 -> 11/00/00. Request at (50,1) -> 00/00/00 with render_valid=1.
- clear_req in IDLE after writes -> busy=1 next cycle, and (5,3) reads 00 after the sweep. A second clear_req mid-sweep does not extend busy beyond 1200 cycles. update_wenable during the sweep is dropped.
- Reset asserted at sweep index 600 -> sweep restarts, and busy stays high for 1200 cycles after the reset is released.
